// File: rtl/button_event.sv
// ---------------------------------------------------------------------------
// button_event
//   Converts the debounced (asynchronous) button level into single-cycle
//   event pulses for downstream control logic: press, release, short click,
//   long press and auto-repeat while the button stays held.
//
// Parameters
//   CLKS_PER_MS : system clock cycles per millisecond
//   LONG_MS     : hold time in ms before a long press is declared (1..65535)
//   REPEAT_MS   : auto-repeat period in ms after a long press, 0 = no repeat
//
// Ports
//   clk_i         : system clock, rising-edge active
//   rst_ni        : asynchronous active-low reset
//   btn_db_i      : debounced button level (1 = pressed), asynchronous
//   held_o        : synchronised button level
//   press_o       : one-cycle pulse on the press edge
//   release_o     : one-cycle pulse on the release edge
//   click_o       : one-cycle pulse on release of a hold shorter than LONG_MS
//   long_press_o  : one-cycle pulse when the hold reaches LONG_MS
//   repeat_o      : one-cycle pulse every REPEAT_MS while in long-hold
// ---------------------------------------------------------------------------
module button_event #(
  parameter int unsigned CLKS_PER_MS = 100000,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned REPEAT_MS   = 200
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_db_i,
  output logic held_o,
  output logic press_o,
  output logic release_o,
  output logic click_o,
  output logic long_press_o,
  output logic repeat_o
);

  localparam int unsigned    PW       = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0]  PRE_MAX  = PW'(CLKS_PER_MS - 1);
  localparam logic [15:0]    LONG_THR = 16'(LONG_MS);
  localparam logic [15:0]    REP_THR  = 16'(REPEAT_MS);
  localparam logic           REP_EN   = (REPEAT_MS != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_LONG    = 2'd2
  } state_e;

  // Synchroniser and edge history
  logic s1_q, s2_q, s3_q;
  logic rise, fall;

  // Timebase
  logic [PW-1:0] pre_q, pre_d;
  logic [15:0]   ms_q, ms_d, ms_inc;
  logic          ms_tick;

  // Control
  state_e state_q, state_d;
  logic   press_q, press_d;
  logic   release_q, release_d;
  logic   click_q, click_d;
  logic   long_q, long_d;
  logic   repeat_q, repeat_d;

  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  assign ms_tick = (pre_q == PRE_MAX);

  // Value the ms counter loads at the coming edge (saturating). Thresholds
  // are compared against this so the pulse registers on the very edge the
  // counter reaches the threshold, giving exactly N*CLKS_PER_MS cycles.
  always_comb begin
    ms_inc = ms_q;
    if (ms_tick && (ms_q != 16'hFFFF)) begin
      ms_inc = ms_q + 16'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    pre_d     = ms_tick ? '0 : pre_q + 1'b1;
    ms_d      = ms_inc;

    if (rise) begin
      pre_d = '0;
      ms_d  = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = S_PRESSED;
        end
      end
      S_PRESSED: begin
        // fall wins over a coincident threshold match
        if (fall) begin
          release_d = 1'b1;
          click_d   = 1'b1;
          state_d   = S_IDLE;
        end else if (ms_inc == LONG_THR) begin
          long_d  = 1'b1;
          ms_d    = '0;
          state_d = S_LONG;
        end
      end
      S_LONG: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = S_IDLE;
        end else if (REP_EN && (ms_inc == REP_THR)) begin
          repeat_d = 1'b1;
          ms_d     = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      pre_q     <= '0;
      ms_q      <= '0;
      state_q   <= S_IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      s1_q      <= btn_db_i;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pre_q     <= pre_d;
      ms_q      <= ms_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
      click_q   <= click_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  // s3 changes on the same edge that registers press/release
  assign held_o       = s3_q;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign click_o      = click_q;
  assign long_press_o = long_q;
  assign repeat_o     = repeat_q;

endmodule

// File: tb/tb_button_event.sv
// ---------------------------------------------------------------------------
// tb_button_event
//   Drives two button_event instances from the same button stimulus: one
//   with auto-repeat (REPEAT_MS=3) and one with repeat disabled (REPEAT_MS=0).
//   Expected outputs come from a hold-length model: the synchronised level is
//   the button delayed by two edges, and pulses follow from the length of the
//   current hold measured in cycles.
// ---------------------------------------------------------------------------
module tb_button_event;

  localparam int unsigned CPM      = 10;
  localparam int unsigned LMS      = 5;
  localparam int unsigned RMS      = 3;
  localparam int          LONG_CYC = 50;   // LMS * CPM
  localparam int          REP_CYC  = 30;   // RMS * CPM

  // Bit positions in the packed output vectors
  localparam int HELD = 5, PRESS = 4, REL = 3, CLICK = 2, LONG = 1, REP = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic btn   = 1'b0;

  logic held_a, press_a, release_a, click_a, long_a, repeat_a;
  logic held_b, press_b, release_b, click_b, long_b, repeat_b;

  button_event #(.CLKS_PER_MS(CPM), .LONG_MS(LMS), .REPEAT_MS(RMS)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .btn_db_i(btn),
    .held_o(held_a), .press_o(press_a), .release_o(release_a),
    .click_o(click_a), .long_press_o(long_a), .repeat_o(repeat_a)
  );

  button_event #(.CLKS_PER_MS(CPM), .LONG_MS(LMS), .REPEAT_MS(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .btn_db_i(btn),
    .held_o(held_b), .press_o(press_b), .release_o(release_b),
    .click_o(click_b), .long_press_o(long_b), .repeat_o(repeat_b)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model state
  int   n;                    // edges since reset release
  bit   btn_log [0:16383];    // button level seen at each edge
  bit   prev_h;
  int   p_cyc;                // cycle of the current press pulse
  logic [5:0] exp_a, exp_b, act_a, act_b;
  int   cnt_a [6];
  int   cnt_b [6];

  function automatic logic [5:0] outs_a();
    return {held_a, press_a, release_a, click_a, long_a, repeat_a};
  endfunction

  function automatic logic [5:0] outs_b();
    return {held_b, press_b, release_b, click_b, long_b, repeat_b};
  endfunction

  task automatic model_reset();
    n      = 0;
    prev_h = 1'b0;
    p_cyc  = 0;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 6; i++) begin
      cnt_a[i] = 0;
      cnt_b[i] = 0;
    end
  endtask

  // Apply one cycle of button level, advance, compute expectations and
  // capture actual outputs (sampled on the falling edge).
  task automatic step(input bit b);
    bit h;
    int d;
    btn = b;
    @(posedge clk);
    n++;
    if (n < 16384) btn_log[n] = b;
    @(negedge clk);
    h = (n >= 3 && n - 2 < 16384) ? btn_log[n-2] : 1'b0;
    d = n - p_cyc;
    exp_a        = '0;
    exp_a[HELD]  = h;
    exp_a[PRESS] = h & ~prev_h;
    exp_a[REL]   = ~h & prev_h;
    exp_a[CLICK] = ~h & prev_h & (d <= LONG_CYC);
    exp_a[LONG]  = h & prev_h & (d == LONG_CYC);
    exp_b        = exp_a;
    exp_a[REP]   = h & prev_h & (d > LONG_CYC) & (((d - LONG_CYC) % REP_CYC) == 0);
    exp_b[REP]   = 1'b0;
    if (h & ~prev_h) p_cyc = n;
    prev_h = h;
    act_a = outs_a();
    act_b = outs_b();
    for (int i = 0; i < 6; i++) begin
      cnt_a[i] += int'(act_a[i]);
      cnt_b[i] += int'(act_b[i]);
    end
  endtask

  task automatic test_reset();
    clear_counts();
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({outs_a(), outs_b()} !== 12'h000) begin
      fails++;
      $display("FAIL reset_init: got a=%b b=%b want 000000", outs_a(), outs_b());
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      tests++;
      if ({act_a, act_b} !== {exp_a, exp_b}) begin
        fails++;
        $display("FAIL reset_press n=%0d: got a=%b b=%b want a=%b b=%b", n, act_a, act_b, exp_a, exp_b);
      end
    end
    // asynchronous reset in the middle of a hold
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({outs_a(), outs_b()} !== 12'h000) begin
      fails++;
      $display("FAIL reset_async: got a=%b b=%b want 000000", outs_a(), outs_b());
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      step(1'b1);
      tests++;
      if ({act_a, act_b} !== {exp_a, exp_b}) begin
        fails++;
        $display("FAIL reset_repress n=%0d: got a=%b b=%b want a=%b b=%b", n, act_a, act_b, exp_a, exp_b);
      end
    end
    tests++;
    if (cnt_a[PRESS] != 1 || act_a[HELD] !== 1'b1) begin
      fails++;
      $display("FAIL reset_newpress: got presses=%0d held=%b want 1 1", cnt_a[PRESS], act_a[HELD]);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      tests++;
      if ({act_a, act_b} !== {exp_a, exp_b}) begin
        fails++;
        $display("FAIL reset_drop n=%0d: got a=%b b=%b want a=%b b=%b", n, act_a, act_b, exp_a, exp_b);
      end
    end
  endtask

  task automatic test_short_hold();
    int hi [5];
    int lo [5];
    clear_counts();
    hi[0] = 30; lo[0] = 20;
    for (int s = 1; s < 5; s++) begin
      hi[s] = int'($urandom_range(2, 45));
      lo[s] = int'($urandom_range(6, 15));
    end
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < hi[s] + lo[s]; i++) begin
        step(i < hi[s]);
        tests++;
        if ({act_a, act_b} !== {exp_a, exp_b}) begin
          fails++;
          $display("FAIL short_hold n=%0d: got a=%b b=%b want a=%b b=%b", n, act_a, act_b, exp_a, exp_b);
        end
      end
    end
    tests++;
    if (cnt_a[PRESS] != 5 || cnt_a[CLICK] != 5 || cnt_a[REL] != 5 || cnt_a[LONG] != 0 || cnt_b[CLICK] != 5) begin
      fails++;
      $display("FAIL short_counts: got press=%0d click=%0d rel=%0d long=%0d clickb=%0d want 5 5 5 0 5",
               cnt_a[PRESS], cnt_a[CLICK], cnt_a[REL], cnt_a[LONG], cnt_b[CLICK]);
    end
  endtask

  task automatic test_long_hold();
    clear_counts();
    for (int i = 0; i < 140; i++) begin
      step(i < 130);
      tests++;
      if ({act_a, act_b} !== {exp_a, exp_b}) begin
        fails++;
        $display("FAIL long_hold n=%0d: got a=%b b=%b want a=%b b=%b", n, act_a, act_b, exp_a, exp_b);
      end
    end
    tests++;
    if (cnt_a[LONG] != 1 || cnt_a[REP] != 2 || cnt_a[CLICK] != 0 || cnt_a[REL] != 1) begin
      fails++;
      $display("FAIL long_counts: got long=%0d rep=%0d click=%0d rel=%0d want 1 2 0 1",
               cnt_a[LONG], cnt_a[REP], cnt_a[CLICK], cnt_a[REL]);
    end
  endtask

  task automatic test_fall_threshold();
    int hi [4];
    hi[0] = 49; hi[1] = 50; hi[2] = 51; hi[3] = 10;
    clear_counts();
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < hi[s] + 8; i++) begin
        step(i < hi[s]);
        tests++;
        if ({act_a, act_b} !== {exp_a, exp_b}) begin
          fails++;
          $display("FAIL fall_thresh n=%0d: got a=%b b=%b want a=%b b=%b", n, act_a, act_b, exp_a, exp_b);
        end
      end
    end
    tests++;
    if (cnt_a[CLICK] != 3 || cnt_a[LONG] != 1 || cnt_a[PRESS] != 4 || cnt_b[LONG] != 1) begin
      fails++;
      $display("FAIL thresh_counts: got click=%0d long=%0d press=%0d longb=%0d want 3 1 4 1",
               cnt_a[CLICK], cnt_a[LONG], cnt_a[PRESS], cnt_b[LONG]);
    end
  endtask

  task automatic test_no_repeat();
    clear_counts();
    for (int i = 0; i < 210; i++) begin
      step(i < 200);
      tests++;
      if ({act_a, act_b} !== {exp_a, exp_b}) begin
        fails++;
        $display("FAIL no_repeat n=%0d: got a=%b b=%b want a=%b b=%b", n, act_a, act_b, exp_a, exp_b);
      end
    end
    tests++;
    if (cnt_b[LONG] != 1 || cnt_b[REP] != 0 || cnt_b[REL] != 1 || cnt_b[CLICK] != 0 || cnt_a[REP] != 4) begin
      fails++;
      $display("FAIL norep_counts: got longb=%0d repb=%0d relb=%0d clickb=%0d repa=%0d want 1 0 1 0 4",
               cnt_b[LONG], cnt_b[REP], cnt_b[REL], cnt_b[CLICK], cnt_a[REP]);
    end
  endtask

  task automatic test_back_to_back();
    int hi [2];
    int lo [2];
    hi[0] = 45; lo[0] = 3;
    hi[1] = 45; lo[1] = 10;
    clear_counts();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < hi[s] + lo[s]; i++) begin
        step(i < hi[s]);
        tests++;
        if ({act_a, act_b} !== {exp_a, exp_b}) begin
          fails++;
          $display("FAIL back_to_back n=%0d: got a=%b b=%b want a=%b b=%b", n, act_a, act_b, exp_a, exp_b);
        end
      end
    end
    tests++;
    if (cnt_a[PRESS] != 2 || cnt_a[REL] != 2 || cnt_a[CLICK] != 2 || cnt_a[LONG] != 0) begin
      fails++;
      $display("FAIL b2b_counts: got press=%0d rel=%0d click=%0d long=%0d want 2 2 2 0",
               cnt_a[PRESS], cnt_a[REL], cnt_a[CLICK], cnt_a[LONG]);
    end
  endtask

  task automatic test_random();
    int hi, lo;
    for (int s = 0; s < 10; s++) begin
      hi = int'($urandom_range(1, 140));
      lo = (s == 9) ? 6 : int'($urandom_range(1, 12));
      for (int i = 0; i < hi + lo; i++) begin
        step(i < hi);
        tests++;
        if ({act_a, act_b} !== {exp_a, exp_b}) begin
          fails++;
          $display("FAIL random n=%0d: got a=%b b=%b want a=%b b=%b", n, act_a, act_b, exp_a, exp_b);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_short_hold();
    test_long_hold();
    test_fall_threshold();
    test_no_repeat();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: got time limit reached want completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
